// File: rtl/mem_stage_bridge.sv
// M-stage load/store responder: turns one pipeline memory op into a split address/data
// bus transaction, stalls the pipeline while it is outstanding and returns extended load data.
//
// state | meaning
// IDLE  | evaluate M-stage op; aligned op requests combinationally, misaligned op flags addr_errM
// REQ   | request held with captured fields until the bus accepts it
// WAIT  | address accepted, waiting for data_data_ok
// DONE  | one cycle with stallM low so the pipeline advances; readdataM holds the result
module mem_stage_bridge #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memtoregM,
   input  logic              memwriteM,
   input  logic [1:0]        sizeM,
   input  logic              loadsignM,
   input  logic              flushM,
   input  logic [ADDR_W-1:0] aluoutM,
   input  logic [31:0]       writedataM,
   output logic              stallM,
   output logic [31:0]       readdataM,
   output logic              addr_errM,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [31:0]       data_wdata,
   output logic [3:0]        data_wstrb,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t              state;
   logic                kill;
   logic [ADDR_W-1:0]   cap_addr;
   logic [1:0]          cap_size;
   logic                cap_wr;
   logic                cap_sign;
   logic [31:0]         cap_wdata;
   logic [3:0]          cap_wstrb;

   logic                mem_op;
   logic                misaligned;
   logic                issue;
   logic [31:0]         lane_wdata;
   logic [3:0]          lane_wstrb;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [31:0]         ld_ext;

   always_comb begin
      mem_op = memtoregM | memwriteM;
      case (sizeM)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = aluoutM[0];
         default: misaligned = |aluoutM[1:0];
      endcase
   end

   assign issue     = (state == S_IDLE) && mem_op && !flushM && !misaligned;
   assign addr_errM = (state == S_IDLE) && mem_op && !flushM && misaligned;

   always_comb begin
      lane_wdata = writedataM;
      lane_wstrb = 4'b1111;
      case (sizeM)
         2'b00: begin
            lane_wdata = {4{writedataM[7:0]}};
            lane_wstrb = 4'b0001 << aluoutM[1:0];
         end
         2'b01: begin
            lane_wdata = {2{writedataM[15:0]}};
            lane_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
      if (!memwriteM)
         lane_wstrb = 4'b0000;
   end

   // The request must be visible in the IDLE cycle itself, so bus fields bypass the capture regs then.
   assign data_req   = issue || (state == S_REQ);
   assign stallM     = issue || (state == S_REQ) || (state == S_WAIT);
   assign data_addr  = issue ? aluoutM    : cap_addr;
   assign data_size  = issue ? sizeM      : cap_size;
   assign data_wr    = issue ? memwriteM  : cap_wr;
   assign data_wdata = issue ? lane_wdata : cap_wdata;
   assign data_wstrb = issue ? lane_wstrb : cap_wstrb;

   always_comb begin
      case (cap_addr[1:0])
         2'd0:    ld_byte = data_rdata[7:0];
         2'd1:    ld_byte = data_rdata[15:8];
         2'd2:    ld_byte = data_rdata[23:16];
         default: ld_byte = data_rdata[31:24];
      endcase
      ld_half = cap_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
      case (cap_size)
         2'b00:   ld_ext = {{24{cap_sign & ld_byte[7]}}, ld_byte};
         2'b01:   ld_ext = {{16{cap_sign & ld_half[15]}}, ld_half};
         default: ld_ext = data_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         kill      <= 1'b0;
         cap_addr  <= '0;
         cap_size  <= 2'b00;
         cap_wr    <= 1'b0;
         cap_sign  <= 1'b0;
         cap_wdata <= 32'h0;
         cap_wstrb <= 4'h0;
         readdataM <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               kill <= 1'b0;
               if (issue) begin
                  cap_addr  <= aluoutM;
                  cap_size  <= sizeM;
                  cap_wr    <= memwriteM;
                  cap_sign  <= loadsignM;
                  cap_wdata <= lane_wdata;
                  cap_wstrb <= lane_wstrb;
                  state     <= data_addr_ok ? S_WAIT : S_REQ;
               end
            end
            S_REQ: begin
               // A flush cannot withdraw an outstanding request; remember it instead.
               if (flushM)
                  kill <= 1'b1;
               if (data_addr_ok)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (flushM)
                  kill <= 1'b1;
               if (data_data_ok) begin
                  if (kill || flushM) begin
                     kill  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     if (!cap_wr)
                        readdataM <= ld_ext;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_bridge.sv
// Bench for mem_stage_bridge: directed scenarios plus randomized load/store traffic checked
// against a transaction-level model of bus fields, stall length and returned load data.
module tb_mem_stage_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        memtoregM, memwriteM, loadsignM, flushM;
   logic [1:0]  sizeM;
   logic [31:0] aluoutM, writedataM;
   logic        stallM, addr_errM, data_req, data_wr;
   logic [31:0] readdataM, data_addr, data_wdata, data_rdata;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_rd;

   always #5 clk = ~clk;

   mem_stage_bridge #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .memtoregM(memtoregM), .memwriteM(memwriteM), .sizeM(sizeM), .loadsignM(loadsignM),
      .flushM(flushM), .aluoutM(aluoutM), .writedataM(writedataM),
      .stallM(stallM), .readdataM(readdataM), .addr_errM(addr_errM),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_wstrb(data_wstrb),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_chk();
      memtoregM = 1'b0; memwriteM = 1'b0; flushM = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      @(negedge clk);
      check("idle_stall", 32'(stallM), 32'd0);
      check("idle_req", 32'(data_req), 32'd0);
      check("idle_err", 32'(addr_errM), 32'd0);
      check("idle_readdata", readdataM, exp_rd);
      next();
   endtask

   // One M-stage instruction; d_a = REQ cycles before acceptance, d_d = extra WAIT cycles.
   task automatic run_op(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int d_a, input int d_d);
      int bytes, sh, n_req, n_wait, stall_cnt;
      bit mis, accepted, finished;
      logic [31:0] e_wdata, e_val;
      logic [3:0]  e_wstrb;
      bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis = (addr % bytes) != 0;
      e_wdata = wd;
      e_wstrb = 4'h0;
      e_val = rd;
      if (st) begin
         if (bytes == 1) begin
            e_wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
            e_wstrb = 4'(1 << (addr % 4));
         end else if (bytes == 2) begin
            e_wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
            e_wstrb = 4'(3 << (2 * ((addr / 2) % 2)));
         end else
            e_wstrb = 4'hF;
      end
      if (bytes == 1) begin
         sh = int'(addr % 4) * 8;
         e_val = (rd >> sh) & 32'hFF;
         if (sg && e_val >= 32'd128) e_val = e_val - 32'd256;
      end else if (bytes == 2) begin
         sh = int'((addr / 2) % 2) * 16;
         e_val = (rd >> sh) & 32'hFFFF;
         if (sg && e_val >= 32'h8000) e_val = e_val - 32'h1_0000;
      end

      memtoregM = ld; memwriteM = st; sizeM = sz; loadsignM = sg;
      aluoutM = addr; writedataM = wd; flushM = 1'b0;
      data_addr_ok = (d_a == 0);
      data_data_ok = 1'($urandom_range(0, 1));
      data_rdata = $urandom;
      @(negedge clk);
      if (mis) begin
         check("mis_err", 32'(addr_errM), 32'd1);
         check("mis_req", 32'(data_req), 32'd0);
         check("mis_stall", 32'(stallM), 32'd0);
         next();
         idle_chk();
         return;
      end
      n_req = 0; n_wait = 0; stall_cnt = 0; accepted = 0; finished = 0;
      for (int c = 0; c < 64 && !finished; c++) begin
         if (c > 0) @(negedge clk);
         if (!stallM) finished = 1;
         else begin
            stall_cnt++;
            if (data_req) begin
               n_req++;
               check("req_addr", data_addr, addr);
               check("req_wr", 32'(data_wr), 32'(st));
               check("req_size", 32'(data_size), 32'(sz));
               check("req_wstrb", 32'(data_wstrb), 32'(e_wstrb));
               if (st) check("req_wdata", data_wdata, e_wdata);
               if (data_addr_ok) accepted = 1;
            end else
               n_wait++;
            next();
            if (!accepted) begin
               data_addr_ok = (n_req == d_a);
               data_data_ok = 1'($urandom_range(0, 1));
               data_rdata = $urandom;
            end else begin
               data_addr_ok = 1'b0;
               data_data_ok = (n_wait == d_d);
               data_rdata = data_data_ok ? rd : $urandom;
            end
         end
      end
      check("op_finished", 32'(finished), 32'd1);
      if (ld) exp_rd = e_val;
      check("stall_cycles", 32'(stall_cnt), 32'(d_a + d_d + 2));
      check("req_cycles", 32'(n_req), 32'(d_a + 1));
      check("done_req", 32'(data_req), 32'd0);
      check("done_readdata", readdataM, exp_rd);
      next();
      idle_chk();
   endtask

   initial begin
      rst = 1'b1;
      memtoregM = 1'b0; memwriteM = 1'b0; sizeM = 2'b00; loadsignM = 1'b0; flushM = 1'b0;
      aluoutM = 32'h0; writedataM = 32'h0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      exp_rd = 32'h0;
      next(); next();
      @(negedge clk);
      check("rst_stall", 32'(stallM), 32'd0);
      check("rst_req", 32'(data_req), 32'd0);
      check("rst_err", 32'(addr_errM), 32'd0);
      check("rst_addr", data_addr, 32'h0);
      check("rst_wdata", data_wdata, 32'h0);
      check("rst_wstrb", 32'(data_wstrb), 32'd0);
      check("rst_readdata", readdataM, 32'h0);
      next();
      rst = 1'b0;
      next();

      run_op(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
      check("lw_const", readdataM, 32'hDEAD_BEEF);
      run_op(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 0);
      check("lb_const", readdataM, 32'hFFFF_FF80);
      run_op(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF_FF7F, 1, 2);
      check("lbu_const", readdataM, 32'h0000_0080);

      // SH 0x102: observe the lane-replicated request in its issue cycle
      memwriteM = 1'b1; sizeM = 2'b01; aluoutM = 32'h102; writedataM = 32'h0000_ABCD;
      data_addr_ok = 1'b0;
      @(negedge clk);
      check("sh_wdata", data_wdata, 32'hABCD_ABCD);
      check("sh_wstrb", 32'(data_wstrb), 32'b1100);
      check("sh_wr", 32'(data_wr), 32'd1);
      next(); data_addr_ok = 1'b1;
      next(); data_addr_ok = 1'b0; data_data_ok = 1'b1;
      next(); data_data_ok = 1'b0;
      @(negedge clk);
      check("sh_done_stall", 32'(stallM), 32'd0);
      next();
      idle_chk();

      run_op(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, 0);
      run_op(1, 0, 2'b10, 0, 32'h1F0, 32'h0, 32'h1357_9BDF, 3, 1);
      run_op(1, 0, 2'b11, 0, 32'h1F4, 32'h0, 32'h2468_ACE0, 0, 3);
      run_op(0, 1, 2'b00, 0, 32'h1F7, 32'hAABB_CC5A, 32'h0, 2, 0);

      // Misaligned but flushed: no error, no request
      memtoregM = 1'b1; sizeM = 2'b10; aluoutM = 32'h101; flushM = 1'b1;
      @(negedge clk);
      check("flush_mis_err", 32'(addr_errM), 32'd0);
      check("flush_mis_req", 32'(data_req), 32'd0);
      next();
      idle_chk();

      // Flush while in WAIT: completes to IDLE without DONE, readdataM untouched
      memtoregM = 1'b1; sizeM = 2'b10; aluoutM = 32'h200; data_addr_ok = 1'b1;
      @(negedge clk);
      check("fw_req", 32'(data_req), 32'd1);
      next(); data_addr_ok = 1'b0; flushM = 1'b1;
      @(negedge clk);
      check("fw_wait_stall", 32'(stallM), 32'd1);
      check("fw_wait_req", 32'(data_req), 32'd0);
      next(); flushM = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
      @(negedge clk);
      check("fw_dok_stall", 32'(stallM), 32'd1);
      next(); memtoregM = 1'b0; data_data_ok = 1'b0;
      @(negedge clk);
      check("fw_after_stall", 32'(stallM), 32'd0);
      check("fw_after_rd", readdataM, exp_rd);
      next();
      idle_chk();

      // Flush while in REQ: request held until accepted, result discarded
      memtoregM = 1'b1; sizeM = 2'b10; aluoutM = 32'h204; data_addr_ok = 1'b0;
      @(negedge clk);
      check("fr_req0", 32'(data_req), 32'd1);
      next(); flushM = 1'b1;
      @(negedge clk);
      check("fr_req_hold", 32'(data_req), 32'd1);
      check("fr_addr_hold", data_addr, 32'h204);
      next(); flushM = 1'b0; data_addr_ok = 1'b1;
      @(negedge clk);
      check("fr_req_acc", 32'(data_req), 32'd1);
      next(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      check("fr_wait_stall", 32'(stallM), 32'd1);
      next(); memtoregM = 1'b0; data_data_ok = 1'b0;
      @(negedge clk);
      check("fr_after_stall", 32'(stallM), 32'd0);
      check("fr_after_rd", readdataM, exp_rd);
      next();
      idle_chk();

      for (int i = 0; i < 40; i++) begin
         bit is_ld;
         is_ld = 1'($urandom_range(0, 1));
         run_op(is_ld, !is_ld, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Reset while in WAIT abandons the transaction
      memwriteM = 1'b1; sizeM = 2'b10; aluoutM = 32'h300; writedataM = 32'h1122_3344;
      data_addr_ok = 1'b1;
      @(negedge clk);
      check("rw_req", 32'(data_req), 32'd1);
      next(); data_addr_ok = 1'b0; memwriteM = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rw_wait_stall", 32'(stallM), 32'd1);
      next(); rst = 1'b0;
      exp_rd = 32'h0;
      @(negedge clk);
      check("rw_stall", 32'(stallM), 32'd0);
      check("rw_req0", 32'(data_req), 32'd0);
      check("rw_addr", data_addr, 32'h0);
      check("rw_wdata", data_wdata, 32'h0);
      check("rw_wstrb", 32'(data_wstrb), 32'd0);
      check("rw_size", 32'(data_size), 32'd0);
      check("rw_wr", 32'(data_wr), 32'd0);
      check("rw_readdata", readdataM, 32'h0);
      next();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
